// File: rtl/graph_render.sv
`default_nettype none
// ============================================================================
// Module      : graph_render
// Description : Per-channel event tally with a scrolling history bar graph.
//               Tallies are sampled every SAMPLE_PERIOD frames into a
//               GRAPH_W-deep history. The vertical scale adapts up and down
//               automatically. Optional grid lines are enabled by defining
//               the macro GRAPH_GRID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module graph_render #(
  parameter int          NUM_CH        = 2,
  parameter int          GRAPH_X       = 640,
  parameter int          GRAPH_Y       = 16,
  parameter int          GRAPH_W       = 128,
  parameter int          GRAPH_H       = 128,
  parameter int          SAMPLE_PERIOD = 16,
  parameter logic [47:0] CH_COLOR      = {12'h0F0, 12'hF00, 12'h00F, 12'hFF0},
  parameter logic [11:0] AXIS_COLOR    = 12'hFFF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [NUM_CH-1:0] alive_in,
  input  logic              count_en_in,
  input  logic              frame_end_in,
  input  logic              freeze_in,
  output logic [11:0]       pix_out,
  output logic [4:0]        scale_out
);

  localparam int PW   = $clog2(GRAPH_W);
  localparam int ZROW = GRAPH_Y + GRAPH_H;

  logic [15:0]   tally_q [NUM_CH];
  logic [15:0]   hist_q  [NUM_CH][GRAPH_W];
  logic [7:0]    period_q, period_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]    scale_q, scale_d;
  logic [15:0]   winmax_q, winmax_d;
  logic [11:0]   pix_q, pix_d;
  logic          commit, wrap, up, down;
  logic [15:0]   cmax, newmax;

  // Commit decision, window maximum tracking and auto-scale next state
  always_comb begin
    cmax = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (tally_q[c] > cmax) cmax = tally_q[c];
    end
    commit = frame_end_in && !freeze_in && (period_q == 8'(SAMPLE_PERIOD - 1));
    wrap   = commit && (wr_ptr_q == PW'(GRAPH_W - 1));
    // The commit that wraps the pointer still belongs to the closing window
    newmax = (cmax > winmax_q) ? cmax : winmax_q;
    up     = commit && (scale_q < 5'd16) &&
             ({32'd0, cmax} >= (48'(GRAPH_H) << scale_q));
    down   = wrap && (scale_q != 5'd0) &&
             ({32'd0, newmax} < (48'(GRAPH_H) << (scale_q - 5'd1)));

    period_d = period_q;
    if (frame_end_in && !freeze_in) period_d = commit ? 8'd0 : period_q + 8'd1;
    wr_ptr_d = commit ? wr_ptr_q + PW'(1) : wr_ptr_q;
    winmax_d = wrap ? 16'd0 : (commit ? newmax : winmax_q);
    scale_d  = scale_q;
    if (up)        scale_d = scale_q + 5'd1;
    else if (down) scale_d = scale_q - 5'd1;
  end

  // Per-frame tallies, sampling state and the scale register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < NUM_CH; c++) tally_q[c] <= '0;
      period_q <= '0;
      wr_ptr_q <= '0;
      scale_q  <= '0;
      winmax_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (frame_end_in)
          tally_q[c] <= '0;
        else if (count_en_in && alive_in[c] && (tally_q[c] != 16'hFFFF))
          tally_q[c] <= tally_q[c] + 16'd1;
      end
      period_q <= period_d;
      wr_ptr_q <= wr_ptr_d;
      scale_q  <= scale_d;
      winmax_q <= winmax_d;
    end
  end

  // History memory: one column per committed sample, written at wr_ptr
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < GRAPH_W; i++) hist_q[c][i] <= '0;
    end else if (commit) begin
      for (int c = 0; c < NUM_CH; c++) hist_q[c][wr_ptr_q] <= tally_q[c];
    end
  end

  logic [PW-1:0] col_idx;
  logic [15:0]   hsh;
  logic [31:0]   hgt, hh, vv;
  logic          in_x;

  // Pixel compositor: grid (optional), then bars (lowest channel wins), then axes
  always_comb begin
    hh      = 32'(hcount_in);
    vv      = 32'(vcount_in);
    in_x    = (hh >= 32'(GRAPH_X)) && (hh < 32'(GRAPH_X + GRAPH_W));
    // Oldest sample sits at the left edge, so column 0 maps to wr_ptr
    col_idx = wr_ptr_q + PW'(hh - 32'(GRAPH_X));
    pix_d   = '0;
    hsh     = '0;
    hgt     = '0;
`ifdef GRAPH_GRID_EN
    for (int k = 0; k < 4; k++) begin
      if (in_x && (vv == 32'(GRAPH_Y + k * (GRAPH_H / 4))))
        pix_d = {1'b0, AXIS_COLOR[11:9], 1'b0, AXIS_COLOR[7:5], 1'b0, AXIS_COLOR[3:1]};
    end
`endif
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      hsh = hist_q[c][col_idx] >> scale_q;
      hgt = (32'(hsh) > 32'(GRAPH_H)) ? 32'(GRAPH_H) : 32'(hsh);
      if (in_x && (vv < 32'(ZROW)) && ((vv + hgt) >= 32'(ZROW)))
        pix_d = CH_COLOR[47 - 12 * c -: 12];
    end
    if ((in_x && (vv == 32'(ZROW))) ||
        ((hh == 32'(GRAPH_X - 1)) && (vv >= 32'(GRAPH_Y)) && (vv <= 32'(ZROW))))
      pix_d = AXIS_COLOR;
  end

  // Registered pixel output, one cycle behind hcount/vcount
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) pix_q <= '0;
    else         pix_q <= pix_d;
  end

  assign pix_out   = pix_q;
  assign scale_out = scale_q;

endmodule
`default_nettype wire

// File: tb/tb_graph_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_graph_render
// Description : Directed self-checking bench for graph_render with a pixel
//               scoreboard queue (expected pixel pushed on drive, popped on
//               the registered output).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_graph_render;

  localparam int GX = 640;
  localparam int GY = 16;
  localparam int GW = 128;
  localparam int GH = 128;
  localparam int Z  = GY + GH;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [1:0]  alive_in = '0;
  logic        count_en_in = 1'b0;
  logic        frame_end_in = 1'b0;
  logic        freeze_in = 1'b0;
  logic [11:0] pix_out;
  logic [4:0]  scale_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  graph_render #(
    .NUM_CH(2), .GRAPH_X(GX), .GRAPH_Y(GY), .GRAPH_W(GW), .GRAPH_H(GH),
    .SAMPLE_PERIOD(1)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .alive_in(alive_in), .count_en_in(count_en_in), .frame_end_in(frame_end_in),
    .freeze_in(freeze_in), .pix_out(pix_out), .scale_out(scale_out)
  );

  always #5 clk_in = ~clk_in;

  // Drive a pixel coordinate, queue its expected colour, compare next cycle
  task automatic probe(input int h, input int v, input logic [11:0] e, input string tag);
    logic [11:0] ev;
    string       et;
    @(negedge clk_in);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_in);
    #1;
    ev = exp_q.pop_front();
    et = tag_q.pop_front();
    n_cmp++;
    assert (pix_out === ev) else begin
      n_bad++;
      $error("FAIL %s: pix_out=%h expected=%h", et, pix_out, ev);
    end
  endtask

  task automatic check_scale(input logic [4:0] e, input string tag);
    n_cmp++;
    assert (scale_out === e) else begin
      n_bad++;
      $error("FAIL %s: scale_out=%0d expected=%0d", tag, scale_out, e);
    end
  endtask

  // One frame: n0/n1 counted events, a non-counted cycle, then frame end
  task automatic frame(input int n0, input int n1);
    int n;
    n = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      count_en_in = 1'b1;
      alive_in    = {1'(i < n1), 1'(i < n0)};
    end
    @(negedge clk_in);
    count_en_in  = 1'b0;
    alive_in     = 2'b11;
    @(negedge clk_in);
    count_en_in  = 1'b1;
    frame_end_in = 1'b1;
    @(negedge clk_in);
    frame_end_in = 1'b0;
    count_en_in  = 1'b0;
    alive_in     = 2'b00;
  endtask

  initial begin
    // Reset state
    #2;
    #1;
    check_scale(5'd0, "rst_scale");
    probe(GX, Z, 12'h000, "rst_pix");
    @(negedge clk_in);
    rst_in = 1'b1;

    // Single bar of 50 at the newest column
    frame(50, 0);
    check_scale(5'd0, "b50_scale");
    probe(GX + 127, Z - 1,  12'h0F0, "b50_bottom");
    probe(GX + 127, Z - 25, 12'h0F0, "b50_mid");
    probe(GX + 127, Z - 50, 12'h0F0, "b50_top");
    probe(GX + 127, Z - 51, 12'h000, "b50_above");
    probe(GX + 126, Z - 1,  12'h000, "empty_col");
    probe(GX,       Z,      12'hFFF, "axis_row");
    probe(GX - 1,   GY,     12'hFFF, "axis_col_top");
    probe(GX - 1,   Z - 5,  12'hFFF, "axis_col_mid");
    probe(GX + GW,  Z - 1,  12'h000, "right_outside");
    probe(0,        Z - 1,  12'h000, "left_outside");

    // Channel priority
    frame(20, 20);
    frame(5, 20);
    probe(GX + 126, Z - 10, 12'h0F0, "tie_ch0");
    probe(GX + 127, Z - 10, 12'hF00, "ch1_taller");
    probe(GX + 127, Z - 3,  12'h0F0, "ch0_over_ch1");
    probe(GX + 127, Z - 21, 12'h000, "above_both");
    probe(GX + 125, Z - 50, 12'h0F0, "scrolled_b50");

    // Freeze: history and pointer hold, tallies still clear
    @(negedge clk_in);
    freeze_in = 1'b1;
    for (int f = 0; f < 5; f++) frame(30, 0);
    @(negedge clk_in);
    freeze_in = 1'b0;
    probe(GX + 127, Z - 10, 12'hF00, "frz_hold");
    frame(4, 0);
    probe(GX + 127, Z - 4,  12'h0F0, "post_frz_top");
    probe(GX + 127, Z - 5,  12'h000, "post_frz_clear");
    probe(GX + 126, Z - 10, 12'hF00, "post_frz_scroll");

    // Upscale on large commits, bar clipped
    frame(300, 0);
    check_scale(5'd1, "up1");
    probe(GX + 127, GY,     12'h0F0, "clip_top");
    probe(GX + 127, GY - 1, 12'h000, "clip_above");
    probe(GX + 126, Z - 2,  12'h0F0, "s1_half_top");
    probe(GX + 126, Z - 3,  12'h000, "s1_half_above");
    frame(300, 0);
    check_scale(5'd2, "up2");
    probe(GX + 127, Z - 75, 12'h0F0, "s2_top");
    probe(GX + 127, Z - 76, 12'h000, "s2_above");

    // Downscale only after a full window of small commits
    for (int i = 0; i < 122; i++) frame(10, 0);
    check_scale(5'd2, "wrap_big_window");
    for (int i = 0; i < 127; i++) frame(10, 0);
    check_scale(5'd2, "pre_wrap_hold");
    frame(10, 0);
    check_scale(5'd1, "down1");

    // Reset mid-frame discards the partial tally and all history
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      count_en_in = 1'b1;
      alive_in    = 2'b01;
    end
    @(negedge clk_in);
    rst_in      = 1'b0;
    count_en_in = 1'b0;
    alive_in    = 2'b00;
    #1;
    check_scale(5'd0, "midrst_scale");
    probe(GX + 127, Z - 1, 12'h000, "midrst_pix");
    @(negedge clk_in);
    rst_in = 1'b1;
    frame(7, 0);
    check_scale(5'd0, "postrst_scale");
    probe(GX + 127, Z - 7, 12'h0F0, "postrst_top");
    probe(GX + 127, Z - 8, 12'h000, "postrst_above");
    probe(GX + 126, Z - 1, 12'h000, "postrst_hist_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
